// File: rtl/wb_sequencer.sv
// Write-back sequencer: initialises the stack pointer after reset, then schedules one register write per request.
// Latency: a write strobes the cycle after acceptance (wb_wait=0), or the cycle after unit_done is sampled (wb_wait=1).
// Backpressure: requests are taken only in IDLE (wb_busy=0); the requester holds wb_req until then.
//
// Ports: clk, reset (async, active high); request side wb_req/wb_src/wb_rd/wb_wait, unit_done from mult/div;
//        register-file side datasrc_sel/reg_wr/reg_wr_addr; status wb_busy/wb_done/sp_init_done.
// Option: define WB_TIMEOUT_EN to bound WAIT_UNIT to TIMEOUT_CYC cycles; this adds the wb_timeout output.
module wb_sequencer #(
  parameter logic [4:0] SP_REG      = 5'd29,
  parameter int         TIMEOUT_CYC = 40
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wb_req,
  input  logic [2:0] wb_src,
  input  logic [4:0] wb_rd,
  input  logic       wb_wait,
  input  logic       unit_done,
  output logic [3:0] datasrc_sel,
  output logic       reg_wr,
  output logic [4:0] reg_wr_addr,
  output logic       wb_busy,
  output logic       wb_done,
  output logic       sp_init_done
`ifdef WB_TIMEOUT_EN
  ,
  output logic       wb_timeout
`endif
);

  typedef enum logic [2:0] {
    ST_RST,
    ST_INIT_SP,
    ST_IDLE,
    ST_WAIT_UNIT,
    ST_WRITE
  } state_t;

  // Mux input 8 carries the stack-pointer initial value.
  localparam logic [3:0] SEL_SP_INIT = 4'b1000;

  state_t     state;
  logic [2:0] src_q;
  logic [4:0] rd_q;

`ifdef WB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmo_cnt;
`endif

  // Outputs are registered together with the state: each branch loads the
  // values that belong to the state being entered, so they are glitch-free
  // Moore outputs of (state, src_q, rd_q).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_RST;
      src_q        <= '0;
      rd_q         <= '0;
      datasrc_sel  <= '0;
      reg_wr       <= 1'b0;
      reg_wr_addr  <= '0;
      wb_busy      <= 1'b1;
      wb_done      <= 1'b0;
      sp_init_done <= 1'b0;
`ifdef WB_TIMEOUT_EN
      tmo_cnt      <= '0;
      wb_timeout   <= 1'b0;
`endif
    end else begin
      // Defaults describe RST / IDLE / WAIT_UNIT; branches override.
      datasrc_sel <= '0;
      reg_wr      <= 1'b0;
      reg_wr_addr <= '0;
      wb_done     <= 1'b0;
      wb_busy     <= 1'b1;
`ifdef WB_TIMEOUT_EN
      wb_timeout  <= 1'b0;
`endif
      case (state)
        ST_RST: begin
          state       <= ST_INIT_SP;
          datasrc_sel <= SEL_SP_INIT;
          reg_wr      <= 1'b1;
          reg_wr_addr <= SP_REG;
        end

        ST_INIT_SP: begin
          state        <= ST_IDLE;
          wb_busy      <= 1'b0;
          sp_init_done <= 1'b1;
        end

        ST_IDLE: begin
          if (wb_req) begin
            src_q <= wb_src;
            rd_q  <= wb_rd;
            if (wb_wait) begin
              state <= ST_WAIT_UNIT;
`ifdef WB_TIMEOUT_EN
              tmo_cnt <= '0;
`endif
            end else begin
              state       <= ST_WRITE;
              datasrc_sel <= {1'b0, wb_src};
              reg_wr      <= (wb_rd != 5'd0);  // r0 is hard-wired
              reg_wr_addr <= wb_rd;
              wb_done     <= 1'b1;
            end
          end else begin
            wb_busy <= 1'b0;
          end
        end

        ST_WAIT_UNIT: begin
          if (unit_done) begin
            state       <= ST_WRITE;
            datasrc_sel <= {1'b0, src_q};
            reg_wr      <= (rd_q != 5'd0);
            reg_wr_addr <= rd_q;
            wb_done     <= 1'b1;
          end
`ifdef WB_TIMEOUT_EN
          // The edge ending the TIMEOUT_CYC-th waiting cycle gives up.
          else if (tmo_cnt == TW'(TIMEOUT_CYC - 1)) begin
            state      <= ST_IDLE;
            wb_busy    <= 1'b0;
            wb_timeout <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end

        ST_WRITE: begin
          state   <= ST_IDLE;
          wb_busy <= 1'b0;
        end

        default: begin
          state <= ST_RST;
        end
      endcase
    end
  end

endmodule
